// File: rtl/apb_master_bridge.sv
// APB requester: takes one command at a time on a valid/ready port, runs SETUP/ACCESS
// with byte strobes, honours wait states with an optional timeout, and returns a response.
module apb_master_bridge #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_SIZE-1:0]   cmd_addr,
  input  logic [DATA_SIZE-1:0]   cmd_wdata,
  input  logic [DATA_SIZE/8-1:0] cmd_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [ADDR_SIZE-1:0]   PADDR,
  output logic [DATA_SIZE-1:0]   PWDATA,
  output logic [DATA_SIZE/8-1:0] PSTROBE,
  input  logic [DATA_SIZE-1:0]   PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  localparam int STRB_W = DATA_SIZE / 8;
  // A zero TIMEOUT still needs a legal (unused) one-bit counter.
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   rsp_timeout_q, rsp_timeout_d;
  logic                   psel_q, psel_d;
  logic                   penable_q, penable_d;
  logic                   pwrite_q, pwrite_d;
  logic [ADDR_SIZE-1:0]   paddr_q, paddr_d;
  logic [DATA_SIZE-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]      pstrobe_q, pstrobe_d;
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrobe_q     <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrobe_q     <= pstrobe_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrobe_d     = pstrobe_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrobe_d   = cmd_write ? cmd_strb : '0;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          wait_cnt_d  = '0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          // Abort on the TIMEOUT-th low PREADY sample.
          if (TIMEOUT != 0 && wait_cnt_d == CNT_W'(TIMEOUT)) begin
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_rdata_d   = '0;
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign PSEL        = psel_q;
  assign PENABLE     = penable_q;
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign PSTROBE     = pstrobe_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: one instance with TIMEOUT=4, one with TIMEOUT=0.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_valid0, cmd_write;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_ready;
  logic [31:0] PRDATA;
  logic        PREADY, PREADY0, PSLVERR;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [5:0]  PADDR;
  logic [3:0]  PSTROBE;

  logic        cmd_ready0, rsp_valid0, rsp_err0, rsp_timeout0;
  logic [31:0] rsp_rdata0, PWDATA0;
  logic        PSEL0, PENABLE0, PWRITE0;
  logic [5:0]  PADDR0;
  logic [3:0]  PSTROBE0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.DATA_SIZE(32), .ADDR_SIZE(6), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTROBE(PSTROBE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_bridge #(.DATA_SIZE(32), .ADDR_SIZE(6), .TIMEOUT(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .rsp_timeout(rsp_timeout0),
    .PSEL(PSEL0), .PENABLE(PENABLE0), .PWRITE(PWRITE0), .PADDR(PADDR0),
    .PWDATA(PWDATA0), .PSTROBE(PSTROBE0), .PRDATA(PRDATA),
    .PREADY(PREADY0), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_valid0 = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0;
    PRDATA = '0; PREADY = 1'b0; PREADY0 = 1'b0; PSLVERR = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    PRESET = 1'b0;
    tick();
    $display("reset done");

    // Zero-wait write
    cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h05; cmd_wdata = 32'h55555555; cmd_strb = 4'hF;
    PREADY = 1;
    tick();
    cmd_valid = 0;
    chk("w0_setup_psel", PSEL, 1);
    chk("w0_setup_penable", PENABLE, 0);
    chk("w0_setup_cmd_ready", cmd_ready, 0);
    chk("w0_paddr", PADDR, 6'h05);
    chk("w0_pwrite", PWRITE, 1);
    chk("w0_pstrobe", PSTROBE, 4'hF);
    chk("w0_pwdata", PWDATA, 32'h55555555);
    tick();
    chk("w0_access_psel", PSEL, 1);
    chk("w0_access_penable", PENABLE, 1);
    tick();
    chk("w0_end_psel", PSEL, 0);
    chk("w0_end_penable", PENABLE, 0);
    chk("w0_rsp_valid", rsp_valid, 1);
    chk("w0_rsp_err", rsp_err, 0);
    chk("w0_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("w0_hs_rsp_valid", rsp_valid, 0);
    chk("w0_hs_cmd_ready", cmd_ready, 1);
    $display("zero-wait write done");

    // Read with 3 wait states; junk PRDATA/PSLVERR while PREADY is low
    cmd_valid = 1; cmd_write = 0; cmd_addr = 6'h05; cmd_wdata = 32'hFFFFFFFF; cmd_strb = 4'hF;
    PREADY = 0; PRDATA = 32'hDEADBEEF; PSLVERR = 1;
    tick();
    cmd_valid = 0;
    chk("r3_pwrite", PWRITE, 0);
    chk("r3_pwdata", PWDATA, 0);
    chk("r3_pstrobe", PSTROBE, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (PENABLE && PSEL) cnt++;
    end
    chk("r3_penable_cycles_before_ready", cnt, 4);
    chk("r3_pwdata_access", PWDATA, 0);
    PREADY = 1; PRDATA = 32'h55555555; PSLVERR = 0;
    tick();
    chk("r3_end_penable", PENABLE, 0);
    chk("r3_rsp_valid", rsp_valid, 1);
    chk("r3_rsp_rdata", rsp_rdata, 32'h55555555);
    chk("r3_rsp_err", rsp_err, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    $display("read with 3 waits done");

    // Slave error on write
    cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h3F; cmd_wdata = 32'h0000A5A5; cmd_strb = 4'h3;
    PREADY = 1; PSLVERR = 1;
    tick();
    cmd_valid = 0;
    chk("err_paddr", PADDR, 6'h3F);
    chk("err_pstrobe", PSTROBE, 4'h3);
    tick(); tick();
    chk("err_rsp_valid", rsp_valid, 1);
    chk("err_rsp_err", rsp_err, 1);
    chk("err_rsp_timeout", rsp_timeout, 0);
    chk("err_rsp_rdata", rsp_rdata, 0);
    PSLVERR = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    $display("slave error done");

    // Timeout with TIMEOUT=4
    cmd_valid = 1; cmd_write = 0; cmd_addr = 6'h10;
    PREADY = 0; PRDATA = 32'hCAFEF00D;
    tick();
    cmd_valid = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (PENABLE) cnt++;
    end
    chk("to_penable_cycles", cnt, 4);
    tick();
    chk("to_psel", PSEL, 0);
    chk("to_penable", PENABLE, 0);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    $display("timeout done");

    // TIMEOUT=0 instance: 100 wait states, no abort
    cmd_valid0 = 1; cmd_write = 0; cmd_addr = 6'h22; PREADY0 = 0;
    tick();
    cmd_valid0 = 0;
    tick();
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (PENABLE0 && !rsp_valid0) cnt++;
    end
    chk("nto_penable_cycles", cnt, 100);
    PREADY0 = 1; PRDATA = 32'h12345678;
    tick();
    chk("nto_rsp_valid", rsp_valid0, 1);
    chk("nto_rsp_timeout", rsp_timeout0, 0);
    chk("nto_rsp_err", rsp_err0, 0);
    chk("nto_rsp_rdata", rsp_rdata0, 32'h12345678);
    chk("nto_main_idle", PSEL, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    PREADY0 = 0;
    $display("no-timeout 100 waits done");

    // Response backpressure with a competing command
    cmd_valid = 1; cmd_write = 0; cmd_addr = 6'h11; PREADY = 1; PRDATA = 32'hA5A5A5A5;
    tick();
    cmd_valid = 0;
    tick(); tick();
    chk("bp_rsp_valid", rsp_valid, 1);
    PRDATA = 32'h0BADF00D;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h2A; cmd_wdata = 32'h600DCAFE; cmd_strb = 4'hC;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid && rsp_rdata == 32'hA5A5A5A5 && !rsp_err && !cmd_ready && !PSEL && PADDR == 6'h11)
        cnt++;
    end
    chk("bp_stable_cycles", cnt, 5);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("bp_hs_rsp_valid", rsp_valid, 0);
    chk("bp_hs_cmd_ready", cmd_ready, 1);
    chk("bp_hs_psel", PSEL, 0);
    tick();
    cmd_valid = 0;
    chk("bp_next_psel", PSEL, 1);
    chk("bp_next_paddr", PADDR, 6'h2A);
    chk("bp_next_cmd_ready", cmd_ready, 0);
    tick(); tick();
    chk("bp_next_rsp_valid", rsp_valid, 1);
    chk("bp_next_rsp_rdata", rsp_rdata, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    $display("backpressure done");

    // Reset during a wait state
    cmd_valid = 1; cmd_write = 0; cmd_addr = 6'h07; PREADY = 0;
    tick();
    cmd_valid = 0;
    tick(); tick();
    chk("rm_pre_penable", PENABLE, 1);
    PRESET = 1;
    #1;
    chk("rm_async_psel", PSEL, 0);
    chk("rm_async_penable", PENABLE, 0);
    #1;
    PRESET = 0;
    chk("rm_cmd_ready", cmd_ready, 1);
    chk("rm_rsp_valid", rsp_valid, 0);
    tick();
    cmd_valid = 1; cmd_write = 1; cmd_addr = 6'h0C; cmd_wdata = 32'h01020304; cmd_strb = 4'h1;
    PREADY = 1; PSLVERR = 0;
    tick();
    cmd_valid = 0;
    chk("rm_next_psel", PSEL, 1);
    chk("rm_next_paddr", PADDR, 6'h0C);
    tick(); tick();
    chk("rm_next_rsp_valid", rsp_valid, 1);
    chk("rm_next_rsp_err", rsp_err, 0);
    chk("rm_next_rsp_timeout", rsp_timeout, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("rm_next_cmd_ready", cmd_ready, 1);
    $display("reset mid-access done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Upstream APB requester that drives the APB slave memory register block (`apb_slv_memory_reg`). It accepts one command at a time on a valid/ready request port and runs the APB SETUP/ACCESS protocol, including PSTROBE byte strobes. It honours slave wait states, ends a stalled transfer after a wait-state timeout, and returns read data plus error status on a valid/ready response port.

## Interface
- DATA_SIZE, 32, APB data width; must be a multiple of 8.
- ADDR_SIZE, 6, APB address width.
- TIMEOUT, 16, maximum wait states before abort; 0 disables the timeout.
- PCLK  in  1  clock, rising-edge.
- PRESET  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_SIZE  target address.
- cmd_wdata  in  DATA_SIZE  write data.
- cmd_strb  in  DATA_SIZE/8  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes and for aborted transfers.
- rsp_err  out  1  PSLVERR seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_SIZE  APB address.
- PWDATA  out  DATA_SIZE  APB write data.
- PSTROBE  out  DATA_SIZE/8  APB strobes.
- PRDATA  in  DATA_SIZE  APB read data.
- PREADY, PSLVERR  in  1  APB completion and error.

## Operation
- **FSM states:** IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- **IDLE**
  - cmd_ready=1; PSEL=0, PENABLE=0.
  - On cmd_valid=1 the command is latched: PADDR=cmd_addr, PWRITE=cmd_write.
  - Writes: PWDATA=cmd_wdata, PSTROBE=cmd_strb. Reads: PWDATA=0, PSTROBE=0.
  - Next state is SETUP.
- **SETUP:** PSEL=1, PENABLE=0, cmd_ready=0. Always lasts exactly one cycle, then ACCESS.
- **ACCESS:** PSEL=1, PENABLE=1. Behaviour depends on PREADY sampled at each edge:
  - PREADY=1:
    - capture rsp_err=PSLVERR and rsp_timeout=0;
    - capture rsp_rdata=PRDATA for reads, 0 for writes;
    - drive PSEL=0, PENABLE=0 and go to RESP.
  - PREADY=0: increment the wait counter (width clog2(TIMEOUT+1)). If TIMEOUT≠0 and the counter reaches TIMEOUT:
    - set rsp_err=1, rsp_timeout=1, rsp_rdata=0;
    - drive PSEL=0, PENABLE=0 and go to RESP.
  - In ACCESS, PSLVERR and PRDATA are ignored while PREADY=0.
- **RESP**
  - rsp_valid=1 and the rsp_* fields are held stable until rsp_ready=1.
  - On handshake: rsp_valid=0 and the next state is IDLE.
  - cmd_ready stays 0 until IDLE, so there is at most one outstanding transfer.
- **Wait counter:** cleared on entry to SETUP.
- **APB stability:** PADDR, PWRITE, PWDATA and PSTROBE stay constant from SETUP through the end of ACCESS. After the transfer they keep their last values; PSEL=0 marks the bus as idle.
- **Reset**
  - Reset values: state IDLE; cmd_ready=1; rsp_valid=0; all other outputs 0.
  - PRESET asserted mid-transfer drops PSEL and PENABLE immediately (asynchronous) and discards any pending response.

## Timing
- Edge numbering: command accepted at edge N, meaning cmd_valid & cmd_ready is high at N.
- PSEL rises after N; PENABLE rises after N+1.
- With w wait states, PREADY is sampled high at edge N+2+w. PSEL/PENABLE fall after that edge and rsp_valid rises after that edge.
- Zero-wait transfer: PSEL high 2 cycles, PENABLE high 1 cycle; rsp_valid 3 cycles after acceptance.
- Timeout: PREADY sampled low at edges N+2 … N+1+TIMEOUT; abort at edge N+1+TIMEOUT. PENABLE is high for exactly TIMEOUT cycles.
- Minimum command-to-command spacing, with rsp_ready tied high: 4 cycles (SETUP, ACCESS, RESP, IDLE).
- No combinational paths from inputs to outputs.

## Test plan
- **Zero-wait write:** cmd addr=0x05, wdata=0x55555555, strb=0xF, slave PREADY=1 → one SETUP cycle then one ACCESS cycle with PADDR=0x05, PWRITE=1, PSTROBE=0xF; rsp_valid after 3 cycles with rsp_err=0.
- **Read with 3 wait states:** cmd read addr=0x05, PREADY low for 3 ACCESS cycles, PRDATA=0x55555555 when PREADY rises → PENABLE high 4 cycles; rsp_rdata=0x55555555; PSTROBE=0 and PWDATA=0 during the transfer.
- **Slave error:** write addr=0x3F, PSLVERR=1 with PREADY=1 → rsp_err=1, rsp_timeout=0.
- **Timeout:** TIMEOUT=4, PREADY held low → PENABLE high exactly 4 cycles, then PSEL=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with TIMEOUT=0 and 100 wait states → no abort.
- **Response backpressure:** rsp_ready low 5 cycles → rsp_* stable, cmd_ready=0, PSEL=0 throughout; a new cmd_valid is not accepted until the cycle after the handshake.
- **Reset mid-ACCESS:** assert PRESET during a wait state → PSEL and PENABLE go low without waiting for a clock edge; after release, cmd_ready=1, rsp_valid=0, and the next command completes normally.
